imem_access_arbiter: RTL and testbench
======================================

// Module: imem_access_arbiter
// PURPOSE
//  Shares the single-port instructions_memory between the CPU fetch stage and
//  the program loader/debug port. One access per clock; reads return 1 cycle later.
//  Sits between fetch/loader and instructions_memory; drives its read_address and
//  write lines, and routes the returned instruction to the requester that issued it.
// PARAMETERS
//  ADDR_WIDTH      32  address width, byte addressed
//  DATA_WIDTH      32  instruction/data width
//  LOAD_BURST_MAX  8   max consecutive load grants while fetch waits in LOAD state (>=1)
// PORTS
//  clock          in   1    system clock, rising edge
//  reset_n        in   1    asynchronous reset, active low
//  fetch_req      in   1    fetch read request; hold with addr until fetch_gnt
//  fetch_addr     in   ADDR fetch address
//  fetch_gnt      out  1    fetch request accepted this cycle (combinational)
//  fetch_rvalid   out  1    fetch_rdata valid (1 cycle after grant)
//  fetch_rdata    out  DATA fetched instruction
//  load_lock      in   1    loader requests priority (program download mode)
//  load_req       in   1    loader request; hold with we/addr/wdata until load_gnt
//  load_we        in   1    1=write, 0=read
//  load_addr      in   ADDR loader address
//  load_wdata     in   DATA loader write data
//  load_gnt       out  1    loader request accepted this cycle (combinational)
//  load_rvalid    out  1    load_rdata valid (1 cycle after read grant)
//  load_rdata     out  DATA loader read data
//  mem_read_address out ADDR address to instructions_memory
//  mem_we         out  1    write strobe to instructions_memory
//  mem_wdata      out  DATA write data to instructions_memory
//  mem_instruction in  DATA instructions_memory output, valid 1 cycle after address
//  load_mode      out  1    1 while in LOAD state
// BEHAVIOUR
//  - Reset (async, reset_n=0): state RUN, burst counter 0, all rvalid/gnt/mem_we/
//    load_mode 0, rdata regs 0, mem_read_address 0. Outstanding read dropped; no rvalid after reset.
//  - At most one of fetch_gnt/load_gnt per cycle. Granted requester's addr drives
//    mem_read_address that cycle; mem_we = load_gnt & load_we; mem_wdata = load_wdata.
//    No grant: mem_read_address holds last value, mem_we=0.
//  - Read latency 1: owner flop captures grantee on read grant; next cycle that
//    requester's rvalid=1 and rdata=mem_instruction (registered at following edge
//    for hold: rdata holds until next rvalid). Writes produce no rvalid.
//  - FSM states:
//    RUN : fetch priority. fetch_req -> fetch_gnt; else load_req -> load_gnt.
//          load_lock=1 sampled -> LOAD next cycle.
//    LOAD: load priority. load_req -> load_gnt, and if fetch_req also high counter++
//          (saturating at LOAD_BURST_MAX). When counter==LOAD_BURST_MAX and fetch_req:
//          fetch_gnt instead, counter<=0. Any fetch grant clears counter.
//          load_lock=0 -> DRAIN.
//    DRAIN: no new grants; waits 1 cycle for outstanding rvalid -> RUN, counter<=0.
//  - load_mode=1 in LOAD and DRAIN.
//  - Request dropped before grant: no effect. Simultaneous req in RUN: fetch wins,
//    load waits. load_lock re-asserted in DRAIN: still returns to RUN first.
//  - Addresses passed unmodified (no wrap logic; memory decodes).
// CONFIGURATION
//  IMEM_ARB_ALIGN_CHECK_EN defined: request with addr[1:0]!=0 gets gnt (consumed)
//   but no memory access (mem_we=0, address not driven); next cycle requester's
//   rvalid=1 with rdata=0 and align_err (extra out, 1 bit) pulses 1 cycle.
//  Not defined: no align_err port; addresses forwarded unchecked.
// TESTING
//  1 reset_n=0 mid-read (fetch granted, addr 0x4) -> no fetch_rvalid, all outputs 0.
//  2 RUN, fetch_req addr 0x8, mem word 0x20080005 -> gnt cycle n, fetch_rvalid n+1,
//    fetch_rdata=0x20080005.
//  3 RUN, fetch_req & load_req same cycle -> fetch_gnt; load_gnt next cycle after
//    fetch_req drops.
//  4 load_lock=1, load writes 0x0..0x1C continuously with fetch_req high ->
//    8 load grants, then 1 fetch grant, counter restarts; mem_we only on load grants.
//  5 load_lock 1->0 while load read outstanding -> load_rvalid delivered in DRAIN,
//    then RUN, load_mode=0.
//  6 (ALIGN_CHECK_EN) fetch addr 0x6 -> gnt, mem_we=0, next cycle rvalid=1, rdata=0,
//    align_err=1.

Source files
------------

// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter: shares the single-port instruction memory between the
// CPU fetch stage and the program loader/debug port. One access per clock,
// reads return one cycle after the grant and are routed back to their issuer.
// Optional build macro: IMEM_ARB_ALIGN_CHECK_EN adds the align_err output and
// turns misaligned requests into consumed, memory-free error responses.
module imem_access_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LOAD_BURST_MAX = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [DATA_WIDTH-1:0] fetch_rdata,
    input  logic                  load_lock,
    input  logic                  load_req,
    input  logic                  load_we,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_wdata,
    output logic                  load_gnt,
    output logic                  load_rvalid,
    output logic [DATA_WIDTH-1:0] load_rdata,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_instruction,
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    output logic                  align_err,
`endif
    output logic                  load_mode
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int CW = $clog2(LOAD_BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOAD_BURST_MAX);

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  own_f_q, own_f_d;   // fetch read outstanding
    logic                  own_l_q, own_l_d;   // loader read outstanding
    logic [DATA_WIDTH-1:0] frdata_q, lrdata_q;
    logic                  f_raw, l_raw;
    logic                  f_mis, l_mis;
    logic [DATA_WIDTH-1:0] rd_word;

`ifdef IMEM_ARB_ALIGN_CHECK_EN
    logic err_q, err_d;
    assign f_mis     = fetch_addr[1:0] != 2'b00;
    assign l_mis     = load_addr[1:0] != 2'b00;
    // An errored request returns zero data instead of whatever memory shows.
    assign rd_word   = err_q ? '0 : mem_instruction;
    assign align_err = err_q;
`else
    assign f_mis     = 1'b0;
    assign l_mis     = 1'b0;
    assign rd_word   = mem_instruction;
`endif

    // Priority selection per state; DRAIN issues nothing so the last read lands.
    always_comb begin
        f_raw = 1'b0;
        l_raw = 1'b0;
        case (state_q)
            ST_RUN: begin
                f_raw = fetch_req;
                l_raw = load_req & ~fetch_req;
            end
            ST_LOAD: begin
                if (fetch_req && cnt_q == CNT_MAX) f_raw = 1'b1;
                else if (load_req)                 l_raw = 1'b1;
                else                               f_raw = fetch_req;
            end
            default: ;
        endcase
    end

    // Grants are forced low while reset is held so every output reads zero.
    assign fetch_gnt = f_raw & reset_n;
    assign load_gnt  = l_raw & reset_n;

    // Memory drive: the grantee's address, otherwise the last driven address.
    always_comb begin
        addr_d = addr_q;
        if (fetch_gnt && !f_mis)     addr_d = fetch_addr;
        else if (load_gnt && !l_mis) addr_d = load_addr;
    end

    assign mem_read_address = addr_d;
    assign mem_we           = load_gnt & load_we & ~l_mis;
    assign mem_wdata        = load_wdata;
    assign load_mode        = state_q != ST_RUN;

    // Next state, burst counter and read-ownership tracking.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        own_f_d = fetch_gnt;
        own_l_d = load_gnt & ~load_we;
`ifdef IMEM_ARB_ALIGN_CHECK_EN
        err_d   = (fetch_gnt & f_mis) | (load_gnt & l_mis);
        // A misaligned write still answers with an error response.
        own_l_d = load_gnt & (~load_we | l_mis);
`endif
        case (state_q)
            ST_RUN: begin
                if (load_lock) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (fetch_gnt)                                   cnt_d = '0;
                else if (load_gnt && fetch_req && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                if (!load_lock) state_d = ST_DRAIN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign fetch_rvalid = own_f_q;
    assign load_rvalid  = own_l_q;
    assign fetch_rdata  = own_f_q ? rd_word : frdata_q;
    assign load_rdata   = own_l_q ? rd_word : lrdata_q;

    // State registers; an outstanding read is dropped by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            addr_q   <= '0;
            own_f_q  <= 1'b0;
            own_l_q  <= 1'b0;
            frdata_q <= '0;
            lrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            own_f_q  <= own_f_d;
            own_l_q  <= own_l_d;
            if (own_f_q) frdata_q <= rd_word;
            if (own_l_q) lrdata_q <= rd_word;
        end
    end

`ifdef IMEM_ARB_ALIGN_CHECK_EN
    // Alignment error pulse, one cycle after the offending grant.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end
`endif

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter with a small instruction-memory model.
module tb_imem_access_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        fetch_req, fetch_gnt, fetch_rvalid;
    logic [31:0] fetch_addr, fetch_rdata;
    logic        load_lock, load_req, load_we, load_gnt, load_rvalid;
    logic [31:0] load_addr, load_wdata, load_rdata;
    logic [31:0] mem_read_address, mem_wdata, mem_instruction;
    logic        mem_we, load_mode;
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [0:255];

    imem_access_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .load_lock(load_lock), .load_req(load_req), .load_we(load_we),
        .load_addr(load_addr), .load_wdata(load_wdata), .load_gnt(load_gnt),
        .load_rvalid(load_rvalid), .load_rdata(load_rdata),
        .mem_read_address(mem_read_address), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_instruction(mem_instruction),
`ifdef IMEM_ARB_ALIGN_CHECK_EN
        .align_err(align_err),
`endif
        .load_mode(load_mode)
    );

    always #5 clock = ~clock;

    // Synchronous-read memory model
    always @(posedge clock) begin
        mem_instruction <= mem[mem_read_address[9:2]];
        if (mem_we) mem[mem_read_address[9:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock); #1;
    endtask

    logic [1:0] gseq [0:11];
    logic [1:0] exp_seq [0:11];
    int k;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[2]  = 32'h20080005;
        mem[4]  = 32'hCAFE0010;
        mem[64] = 32'h0BADF00D;
        mem_instruction = '0;
        reset_n = 1'b0;
        fetch_req = 0; fetch_addr = 0; load_lock = 0; load_req = 0;
        load_we = 0; load_addr = 0; load_wdata = 0;
        tick; tick;
        reset_n = 1'b1;
        tick;

        // 1: reset in the middle of a fetch read
        fetch_req = 1; fetch_addr = 32'h4;
        #1 chk("t1_gnt_before_rst", fetch_gnt, 1);
        #1 reset_n = 1'b0;
        #1 chk("t1_gnt_in_rst", fetch_gnt, 0);
        chk("t1_addr_in_rst", mem_read_address, 0);
        chk("t1_mode_in_rst", load_mode, 0);
        tick;
        chk("t1_rvalid", fetch_rvalid, 0);
        chk("t1_rdata", fetch_rdata, 0);
        chk("t1_mem_we", mem_we, 0);
        fetch_req = 0;
        #2 reset_n = 1'b1;
        tick;

        // 2: plain fetch, one-cycle latency and rdata hold
        fetch_req = 1; fetch_addr = 32'h8;
        #1 chk("t2_gnt", fetch_gnt, 1);
        chk("t2_addr", mem_read_address, 32'h8);
        chk("t2_we", mem_we, 0);
        tick;
        fetch_req = 0;
        chk("t2_rvalid", fetch_rvalid, 1);
        chk("t2_rdata", fetch_rdata, 32'h20080005);
        #1 chk("t2_addr_hold", mem_read_address, 32'h8);
        tick;
        chk("t2_rvalid_off", fetch_rvalid, 0);
        chk("t2_rdata_hold", fetch_rdata, 32'h20080005);

        // 3: simultaneous requests in RUN, fetch wins
        fetch_req = 1; fetch_addr = 32'hC;
        load_req = 1; load_we = 0; load_addr = 32'h10;
        #1 chk("t3_fgnt", fetch_gnt, 1);
        chk("t3_lgnt_wait", load_gnt, 0);
        tick;
        fetch_req = 0;
        #1 chk("t3_lgnt", load_gnt, 1);
        chk("t3_fgnt_off", fetch_gnt, 0);
        tick;
        load_req = 0;
        chk("t3_lrvalid", load_rvalid, 1);
        chk("t3_lrdata", load_rdata, 32'hCAFE0010);
        chk("t3_frvalid_off", fetch_rvalid, 0);

        // 4: load burst limit with fetch waiting
        load_lock = 1;
        tick;
        chk("t4_mode", load_mode, 1);
        for (int i = 0; i < 12; i++) exp_seq[i] = 2'b01;
        exp_seq[8] = 2'b10; exp_seq[11] = 2'b10;
        k = 0;
        fetch_req = 1; fetch_addr = 32'h100;
        for (int c = 0; c < 12; c++) begin
            load_req = (k < 10); load_we = 1;
            load_addr = 32'(k * 4); load_wdata = 32'hA0 + 32'(k);
            #1;
            gseq[c] = {fetch_gnt, load_gnt};
            chk($sformatf("t4_we_c%0d", c), mem_we, load_gnt);
            if (load_gnt) k++;
            tick;
        end
        fetch_req = 0; load_req = 0; load_we = 0;
        for (int c = 0; c < 12; c++) chk($sformatf("t4_grant_c%0d", c), gseq[c], exp_seq[c]);
        chk("t4_frvalid", fetch_rvalid, 1);
        chk("t4_frdata", fetch_rdata, 32'h0BADF00D);
        chk("t4_mem7", mem[7], 32'hA7);
        chk("t4_mem9", mem[9], 32'hA9);

        // 5: lock drops with a load read in flight
        load_req = 1; load_we = 0; load_addr = 32'h8; load_lock = 0;
        #1 chk("t5_lgnt", load_gnt, 1);
        tick;
        load_req = 0; fetch_req = 1; fetch_addr = 32'hC; load_lock = 1;
        #1 chk("t5_lrvalid", load_rvalid, 1);
        chk("t5_lrdata", load_rdata, 32'hA2);
        chk("t5_drain_nognt", fetch_gnt, 0);
        chk("t5_drain_mode", load_mode, 1);
        tick;
        #1 chk("t5_run_mode", load_mode, 0);
        chk("t5_run_fgnt", fetch_gnt, 1);
        tick;
        fetch_req = 0; load_lock = 0;
        chk("t5_frdata", fetch_rdata, 32'hA3);
        chk("t5_relock_mode", load_mode, 1);
        tick; tick;
        chk("t5_back_run", load_mode, 0);

`ifdef IMEM_ARB_ALIGN_CHECK_EN
        // 6: misaligned fetch is consumed without a memory access
        fetch_req = 1; fetch_addr = 32'h6;
        #1 chk("t6_gnt", fetch_gnt, 1);
        chk("t6_we", mem_we, 0);
        chk("t6_addr_held", mem_read_address, 32'hC);
        tick;
        fetch_req = 0;
        chk("t6_rvalid", fetch_rvalid, 1);
        chk("t6_rdata", fetch_rdata, 0);
        chk("t6_err", align_err, 1);
        tick;
        chk("t6_err_off", align_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
